// File: rtl/led_pkg.sv
// Shared constants for the LED sequencer: mode encodings and prescaler sizing.
package led_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RING   = 2'b11;

  // Prescaler counter width: enough bits for 0..div-1, never less than one bit.
  function automatic int unsigned pcnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Prescaler: emits a combinational tick event every DIV enabled cycles.
module tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic pmod,
  input  logic en,
  input  logic clr,
  output logic tick_evt
);

  localparam int unsigned PW = pcnt_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  assign tick_evt = en & (pcnt == LAST);

  // clr restarts the period so the next event is a full DIV enabled cycles away.
  always_ff @(posedge clk or negedge pmod) begin
    if (!pmod) begin
      pcnt <= '0;
    end else if (clr || tick_evt) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: up/down/bounce/ring sequences advanced by a prescaled tick.
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 12000000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             pmod,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned DIV = (TICK_HZ == 0) ? 1 : CLK_HZ / TICK_HZ;

  generate
    if (TICK_HZ == 0 || TICK_HZ > CLK_HZ || WIDTH < 2 || WIDTH > 32) begin : g_bad_params
      $error("led_sequencer: illegal CLK_HZ/TICK_HZ/WIDTH combination");
    end
  endgenerate

  logic             tick_evt;
  logic             dir;
  logic [WIDTH-1:0] nxt;
  logic             nxt_dir;
  logic             nxt_wrap;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk      (clk),
    .pmod     (pmod),
    .en       (en),
    .clr      (load),
    .tick_evt (tick_evt)
  );

  // Candidate value for the next tick; only committed when tick_evt fires.
  always_comb begin
    nxt      = led;
    nxt_dir  = 1'b0;
    nxt_wrap = 1'b0;
    case (mode)
      MODE_UP: begin
        nxt      = led + WIDTH'(1);
        nxt_wrap = &led;
      end
      MODE_DOWN: begin
        nxt      = led - WIDTH'(1);
        nxt_wrap = ~|led;
      end
      MODE_BOUNCE: begin
        if (!dir) begin
          if (&led) begin
            nxt      = led - WIDTH'(1);
            nxt_dir  = 1'b1;
            nxt_wrap = 1'b1;
          end else begin
            nxt      = led + WIDTH'(1);
          end
        end else begin
          if (~|led) begin
            nxt      = WIDTH'(1);
            nxt_wrap = 1'b1;
          end else begin
            nxt      = led - WIDTH'(1);
            nxt_dir  = 1'b1;
          end
        end
      end
      MODE_RING: begin
        // A corrupted (non-one-hot) pattern re-seeds the ring instead of rotating.
        if ($onehot(led)) begin
          nxt      = {led[WIDTH-2:0], led[WIDTH-1]};
          nxt_wrap = led[WIDTH-1];
        end else begin
          nxt      = WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge pmod) begin
    if (!pmod) begin
      led  <= '0;
      dir  <= 1'b0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      led  <= load_val;
      dir  <= 1'b0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= tick_evt;
      wrap <= tick_evt & nxt_wrap;
      if (tick_evt) begin
        led <= nxt;
        dir <= nxt_dir;
      end else if (mode != MODE_BOUNCE) begin
        dir <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: sequence-level model checked every cycle plus pinned literals.
module tb_led_sequencer;

  typedef struct {
    int v;
    int d;
    int cnt;
    bit tick;
    bit wrap;
  } mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DIV = 4
  logic       pmod_a = 1'b0, en_a = 1'b0, load_a = 1'b0;
  logic [1:0] mode_a = 2'b00;
  logic [3:0] load_val_a = 4'd0;
  logic [3:0] led_a;
  logic       tick_a, wrap_a;

  // Instance B: DIV = 1
  logic       pmod_b = 1'b0, en_b = 1'b0, load_b = 1'b0;
  logic [1:0] mode_b = 2'b00;
  logic [3:0] load_val_b = 4'd0;
  logic [3:0] led_b;
  logic       tick_b, wrap_b;

  led_sequencer #(.CLK_HZ(8), .TICK_HZ(2), .WIDTH(4)) dut_a (
    .clk(clk), .pmod(pmod_a), .en(en_a), .mode(mode_a), .load(load_a),
    .load_val(load_val_a), .led(led_a), .tick(tick_a), .wrap(wrap_a));

  led_sequencer #(.CLK_HZ(5), .TICK_HZ(5), .WIDTH(4)) dut_b (
    .clk(clk), .pmod(pmod_b), .en(en_b), .mode(mode_b), .load(load_b),
    .load_val(load_val_b), .led(led_b), .tick(tick_b), .wrap(wrap_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Sequence model: led as an integer, direction as +1/-1, elapsed enabled cycles.
  function automatic mst_t mstep(input mst_t s, input int div, input bit en,
                                 input bit [1:0] mode, input bit ld, input int lv);
    mst_t n;
    int   nv;
    n = s;
    n.tick = 1'b0;
    n.wrap = 1'b0;
    if (ld) begin
      n.v = lv; n.cnt = 0; n.d = 1;
      return n;
    end
    if (en) begin
      n.cnt = s.cnt + 1;
      if (n.cnt == div) begin
        n.cnt = 0;
        n.tick = 1'b1;
        case (mode)
          2'd0: begin n.v = (s.v + 1) % 16; n.wrap = (s.v == 15); end
          2'd1: begin n.v = (s.v + 15) % 16; n.wrap = (s.v == 0); end
          2'd2: begin
            nv = s.v + s.d;
            if (nv > 15) begin nv = 14; n.d = -1; n.wrap = 1'b1; end
            else if (nv < 0) begin nv = 1; n.d = 1; n.wrap = 1'b1; end
            n.v = nv;
          end
          default: begin
            if ($countones(s.v) == 1) begin
              n.v = (s.v * 2) % 16 + s.v / 8;
              n.wrap = (s.v == 8);
            end else begin
              n.v = 1;
            end
          end
        endcase
      end
    end
    if (mode != 2'd2) n.d = 1;
    return n;
  endfunction

  mst_t sa = '{0, 1, 0, 1'b0, 1'b0};
  mst_t sb = '{0, 1, 0, 1'b0, 1'b0};

  always @(posedge clk or negedge pmod_a)
    if (!pmod_a) sa <= '{0, 1, 0, 1'b0, 1'b0};
    else         sa <= mstep(sa, 4, en_a, mode_a, load_a, int'(load_val_a));

  always @(posedge clk or negedge pmod_b)
    if (!pmod_b) sb <= '{0, 1, 0, 1'b0, 1'b0};
    else         sb <= mstep(sb, 1, en_b, mode_b, load_b, int'(load_val_b));

  always @(negedge clk) begin
    chk("A led",  int'(led_a),  sa.v);
    chk("A tick", int'(tick_a), int'(sa.tick));
    chk("A wrap", int'(wrap_a), int'(sa.wrap));
    chk("B led",  int'(led_b),  sb.v);
    chk("B tick", int'(tick_b), int'(sb.tick));
    chk("B wrap", int'(wrap_b), int'(sb.wrap));
  end

  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (wrap_a) wcnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    chk("reset led", int'(led_a), 0);
    chk("reset tick", int'(tick_a), 0);

    // Up count through a full wrap
    pmod_a = 1'b1; en_a = 1'b1; mode_a = 2'd0; wcnt = 0;
    cyc(4);
    chk("up first tick led", int'(led_a), 1);
    chk("up first tick", int'(tick_a), 1);
    cyc(60);
    chk("up wrapped led", int'(led_a), 0);
    chk("up wrap count", wcnt, 1);

    // Bounce from 0: 1..15, 14..0, then 1
    load_a = 1'b1; load_val_a = 4'd0; mode_a = 2'd2;
    cyc(1);
    load_a = 1'b0; wcnt = 0;
    cyc(124);
    chk("bounce led", int'(led_a), 1);
    chk("bounce wrap count", wcnt, 2);

    // Ring from 0 re-seeds to 1, then 2,4,8,1
    load_a = 1'b1; load_val_a = 4'd0; mode_a = 2'd3;
    cyc(1);
    load_a = 1'b0; wcnt = 0;
    cyc(20);
    chk("ring led", int'(led_a), 1);
    chk("ring wrap count", wcnt, 1);
    load_a = 1'b1; load_val_a = 4'b0110;
    cyc(1);
    load_a = 1'b0; wcnt = 0;
    cyc(4);
    chk("ring reseed led", int'(led_a), 1);
    chk("ring reseed tick", int'(tick_a), 1);
    chk("ring reseed wrap", wcnt, 0);

    // Load coinciding with a tick event
    cyc(3);
    load_a = 1'b1; load_val_a = 4'd9; mode_a = 2'd0;
    cyc(1);
    load_a = 1'b0;
    chk("load led", int'(led_a), 9);
    chk("load tick", int'(tick_a), 0);
    cyc(3);
    chk("post-load no early tick", int'(tick_a), 0);
    cyc(1);
    chk("post-load tick", int'(tick_a), 1);
    chk("post-load led", int'(led_a), 10);

    // Freeze mid-period; mode wiggle between ticks must not matter
    cyc(2);
    en_a = 1'b0; mode_a = 2'd1;
    cyc(10);
    chk("frozen led", int'(led_a), 10);
    mode_a = 2'd0; en_a = 1'b1;
    cyc(1);
    chk("resume no tick", int'(tick_a), 0);
    cyc(1);
    chk("resume tick", int'(tick_a), 1);
    chk("resume led", int'(led_a), 11);

    // DIV = 1, counting down every enabled cycle
    pmod_b = 1'b1; en_b = 1'b1; mode_b = 2'd1;
    cyc(1);
    chk("B first led", int'(led_b), 15);
    chk("B first wrap", int'(wrap_b), 1);
    cyc(4);
    chk("B led after 5", int'(led_b), 11);
    @(posedge clk);
    #2 pmod_b = 1'b0;
    #1;
    chk("B async reset led", int'(led_b), 0);
    chk("B async reset tick", int'(tick_b), 0);
    @(negedge clk);
    pmod_b = 1'b1;
    cyc(3);
    chk("B restart led", int'(led_b), 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, meaning the LED update rate in Hz; DIV = CLK_HZ/TICK_HZ (integer division).
REQ-003 SHALL have parameter WIDTH, default 4, meaning the LED/value width; legal range 2..32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port pmod, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: prescaler run enable.
REQ-007 SHALL have port mode, input, 2 bits: sequence select; 00 up, 01 down, 10 bounce, 11 ring.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH bits: value applied on load.
REQ-010 SHALL have port led, output, WIDTH bits: current sequence value, registered.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse, high in the cycle led shows a tick-updated value.
REQ-012 SHALL have port wrap, output, 1 bit: one-cycle pulse, coincident with tick, on a sequence wrap or turnaround.

Function
REQ-013 SHALL fail elaboration if TICK_HZ = 0, TICK_HZ > CLK_HZ, or WIDTH is outside 2..32.
REQ-014 SHALL have a prescaler pcnt of width max(1,clog2(DIV)) counting 0..DIV-1 while en=1, holding while en=0.
REQ-015 SHALL make the tick event occur on the edge where en=1 and pcnt=DIV-1, setting pcnt to 0; the tick period is exactly DIV enabled cycles.
REQ-016 SHALL, with DIV=1, make every enabled cycle a tick event.
REQ-017 SHALL, on a tick event, update led and set tick=1 on the same edge; tick and wrap SHALL be 0 on every other edge.
REQ-018 SHALL, in mode up, set led to led+1 modulo 2^WIDTH, with wrap=1 when the old led is all-ones.
REQ-019 SHALL, in mode down, set led to led-1 modulo 2^WIDTH, with wrap=1 when the old led is 0.
REQ-020 SHALL, in mode bounce, use an internal dir flag (0=up): count up until all-ones then down until 0, never wrapping numerically; at all-ones going up, dir flips and led goes to all-ones-1; at 0 going down, dir flips and led goes to 1; wrap=1 on each flip.
REQ-021 SHALL clear dir whenever mode is not bounce.
REQ-022 SHALL, in mode ring, rotate led left by one, with wrap=1 when the old MSB is 1; if the old led is not one-hot, led becomes 1 with wrap=0.
REQ-023 SHALL sample mode only at tick events; a mode change between ticks SHALL NOT alter led.
REQ-024 SHALL, when load=1, set led=load_val, pcnt=0, dir=0, tick=0, and wrap=0, regardless of en or a coincident tick event (load wins).
REQ-025 SHALL, when en=0, hold led, pcnt, and dir; load SHALL still act.

Reset
REQ-026 SHALL, when pmod=0, asynchronously force led=0, pcnt=0, dir=0, tick=0, and wrap=0.
REQ-027 SHALL, after pmod rises, restart counting from pcnt=0, giving the first tick DIV enabled cycles later; a reset mid-period SHALL discard the partial period.

Structure
REQ-028 SHALL place the mode encodings (MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_RING) as constants in shared package led_pkg.
REQ-029 SHALL implement the prescaler as sub-module tick_gen (parameter DIV; ports clk, pmod, en, clr, tick_evt).
REQ-030 SHALL keep next-value selection combinational, with all outputs driven directly from registers.

Verification (CLK_HZ=8, TICK_HZ=2 so DIV=4, WIDTH=4, unless stated)
REQ-031 SHALL cover: pmod low, then released with en=1, mode=up -> tick every 4 cycles; led 0,1,2..15,0; wrap only on the 15->0 tick.
REQ-032 SHALL cover: mode=bounce from led=0 -> led 1..15,14..0,1; wrap on the ticks producing 14 and 1.
REQ-033 SHALL cover: mode=ring with led=0 -> 1,2,4,8,1; wrap on the 8->1 tick; load_val=4'b0110 then a tick -> led=1, wrap=0.
REQ-034 SHALL cover: load=1 with load_val=9 on a tick-event cycle -> led=9, tick=0, and the next tick exactly 4 cycles later.
REQ-035 SHALL cover: en low for 10 cycles mid-period at pcnt=2 -> led frozen; the tick arrives 2 enabled cycles after en rises.
REQ-036 SHALL cover: CLK_HZ=TICK_HZ (DIV=1), mode=down -> led decrements every enabled cycle; pmod pulsed low mid-run -> outputs 0 immediately, without waiting for a clock edge.
